// File: rtl/serial_add_sub.sv
// Digit-serial W-bit adder/subtractor: DIGIT bits per clock with a registered inter-digit carry.
// Optional macro ADDSUB_SAT_EN clamps the result to signed saturation on overflow.
module serial_add_sub #(
  parameter int W     = 32,
  parameter int DIGIT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         ready,
  output logic         done,
  output logic [W-1:0] result,
  output logic         cout,
  output logic         ovf
);

  localparam int K  = W / DIGIT;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_next;
  logic [W-1:0]   a_sh, b_sh;
  logic           carry;
  logic [CW-1:0]  cnt;
  logic [DIGIT:0] digit_sum;
  logic           last;
  logic           carry_msb;
  logic           ovf_raw;
  logic [W-1:0]   result_shift;
  logic [W-1:0]   result_next;

`ifdef ADDSUB_SAT_EN
  function automatic logic [W-1:0] sat_value(input logic neg);
    sat_value = neg ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  endfunction
`endif

  // One DIGIT-wide ripple slice; the operand registers present their low digit each cycle.
  assign digit_sum    = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]}
                      + {{DIGIT{1'b0}}, carry};
  assign last         = (cnt == CW'(K - 1));
  // On the last digit, bit DIGIT-1 of the slice is bit W-1 of the word.
  assign carry_msb    = a_sh[DIGIT-1] ^ b_sh[DIGIT-1] ^ digit_sum[DIGIT-1];
  assign ovf_raw      = carry_msb ^ digit_sum[DIGIT];
  assign result_shift = (result >> DIGIT) | (W'(digit_sum[DIGIT-1:0]) << (W - DIGIT));

  always_comb begin
    result_next = result_shift;
`ifdef ADDSUB_SAT_EN
    // a_sh[DIGIT-1] holds the original a[W-1] once the last digit is reached.
    if (last && ovf_raw) result_next = sat_value(a_sh[DIGIT-1]);
`endif
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_next = RUN;
      end
      RUN: begin
        if (last) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> DIGIT;
          b_sh   <= b_sh >> DIGIT;
          carry  <= digit_sum[DIGIT];
          cnt    <= cnt + CW'(1);
          result <= result_next;
          if (last) begin
            cout <= digit_sum[DIGIT];
            ovf  <= ovf_raw;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_sub.sv
// Self-checking bench for serial_add_sub: directed cases, abort by reset, random ops, back-to-back spacing.
// Honours ADDSUB_SAT_EN in its reference model.
module tb_serial_add_sub;
  parameter int W     = 32;
  parameter int DIGIT = 4;
  localparam int K = W / DIGIT;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;

  int errors = 0;
  int checks = 0;
  logic [W+1:0] exp_q[$];

  serial_add_sub #(.W(W), .DIGIT(DIGIT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
    .ready(ready), .done(done), .result(result), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Reference: whole-word modulo arithmetic; returns {ovf, cout, result}.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic s);
    logic [W:0]   full;
    logic [W-1:0] yy;
    logic [W-1:0] r;
    logic         o;
    yy   = s ? ~y : y;
    full = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, s};
    r    = full[W-1:0];
    o    = (x[W-1] == yy[W-1]) && (r[W-1] != x[W-1]);
`ifdef ADDSUB_SAT_EN
    if (o) r = x[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
    return {o, full[W], r};
  endfunction

  function automatic logic [W-1:0] rnd();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[W-1:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    assert (got === want)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [W+1:0] e);
    check({tag, "_result"}, 64'(result), 64'(e[W-1:0]));
    check({tag, "_cout"}, 64'(cout), 64'(e[W]));
    check({tag, "_ovf"}, 64'(ovf), 64'(e[W+1]));
  endtask

  // One operation; optionally re-pulses start with other operands while running.
  task automatic op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tbv,
                    input logic ts, input logic mid);
    logic [W+1:0] e;
    int lat;
    e = model(ta, tbv, ts);
    @(negedge clk);
    check({tag, "_ready_idle"}, 64'(ready), 64'd1);
    a = ta; b = tbv; sub = ts; start = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    start = mid; a = rnd(); b = rnd(); sub = ~ts;
    check({tag, "_ready_run"}, 64'(ready), 64'd0);
    while (!done && lat < 4 * K + 10) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      start = 1'b0;
    end
    check({tag, "_latency"}, 64'(lat), 64'(K + 1));
    check({tag, "_done"}, 64'(done), 64'd1);
    check_outputs(tag, e);
  endtask

  task automatic pop_and_check(input string tag);
    logic [W+1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_unexpected_done"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check_outputs(tag, e);
    end
  endtask

  initial begin
    int last_done;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_done", 64'(done), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);

    op("add_small", W'(32'h0000_0005), W'(32'h0000_0003), 1'b0, 1'b0);
    op("add_wrap", W'(32'hFFFF_FFFF), W'(32'h0000_0001), 1'b0, 1'b0);
    op("sub_neg", W'(32'h0000_0003), W'(32'h0000_0005), 1'b1, 1'b0);
    op("add_ovf", W'(32'h7FFF_FFFF), W'(32'h0000_0001), 1'b0, 1'b0);
    op("sub_ovf", W'(32'h8000_0000), W'(32'h0000_0001), 1'b1, 1'b0);

    // Abort by reset right after acceptance.
    @(negedge clk);
    a = rnd(); b = rnd(); sub = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b0;
    #1;
    check("abort_result", 64'(result), 64'd0);
    check("abort_cout", 64'(cout), 64'd0);
    check("abort_ovf", 64'(ovf), 64'd0);
    check("abort_ready", 64'(ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_done", 64'(done), 64'd0);
    end
    rst_n = 1'b1;
    op("after_abort", rnd(), rnd(), 1'b1, 1'b0);

    op("ignored_start", W'(32'h1234_5678), W'(32'h0FED_CBA9), 1'b0, 1'b1);

    for (int i = 0; i < 16; i++)
      op("rand", rnd(), rnd(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    // Back-to-back: start held high, new operands loaded whenever ready.
    last_done = -1;
    start = 1'b1;
    for (int c = 0; c < 5 * (K + 2); c++) begin
      @(negedge clk);
      if (done) begin
        pop_and_check("b2b");
        if (last_done >= 0) check("b2b_spacing", 64'(c - last_done), 64'(K + 2));
        last_done = c;
      end
      if (ready) begin
        a = rnd(); b = rnd(); sub = 1'($urandom_range(0, 1));
        exp_q.push_back(model(a, b, sub));
      end
    end
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4 * K + 10 && exp_q.size() > 0; i++) begin
      if (done) pop_and_check("b2b_drain");
      if (exp_q.size() > 0) @(negedge clk);
    end
    check("b2b_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
